// File: rtl/obj_fetch.sv
// obj_fetch: fetches one heap object per request and returns it in decoded form.
//
// The header byte at the object pointer selects the object type. After that, the
// remaining bytes are read one at a time. Each byte takes two cycles: one cycle to
// issue the read, and one cycle to capture the data.
//
// Object formats:
//   NUMBER    (tag 0): 2 bytes, value in byte 1
//   FUNC_PRIM (tag 2): 2 bytes, primitive id in byte 1
//   CONS      (tag 1): 5 bytes, car = {b1[3:0], b2}, cdr = {b3[3:0], b4}
//
// A NIL pointer (0) is answered immediately, without any heap access.
// Two cases are reported as errors after the header read: an unknown tag, and an
// object whose bytes would run past the top of the heap.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake; req_addr is the object pointer
//   mem_rd_en/mem_addr        heap read strobe and address
//   mem_rd_data               heap data, valid the cycle after mem_rd_en
//   rsp_valid/rsp_ready       response handshake
//   rsp_header                type tag
//   rsp_word0/rsp_word1       decoded payload
//   rsp_nil/rsp_error         response status flags
module obj_fetch #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_header,
  output logic [ADDR_WIDTH-1:0] rsp_word0,
  output logic [ADDR_WIDTH-1:0] rsp_word1,
  output logic                  rsp_nil,
  output logic                  rsp_error
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [DATA_WIDTH-1:0] TAG_CONS = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] TAG_LIM  = DATA_WIDTH'(3);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            idx;
  logic [2:0]            last_idx;
  logic                  is_cons;
  logic [DATA_WIDTH-1:0] tag;
  logic [DATA_WIDTH-1:0] byte_buf [4];

  // Header decode. It looks at mem_rd_data directly and is used only in the
  // CAPTURE cycle for byte 0.
  logic                  hdr_cons;
  logic                  hdr_bad;
  logic [2:0]            hdr_last;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  overrun;
  logic [2:0]            nxt_idx;

  function automatic logic [ADDR_WIDTH-1:0] zext(input logic [DATA_WIDTH-1:0] d);
    return ADDR_WIDTH'(d);
  endfunction

  // Builds a 12-bit pointer from the low nibble of the high byte and the full low byte.
  function automatic logic [ADDR_WIDTH-1:0] ptr12(input logic [DATA_WIDTH-1:0] hi,
                                                  input logic [DATA_WIDTH-1:0] lo);
    logic [11:0] p;
    p = {hi[3:0], lo[7:0]};
    return ADDR_WIDTH'(p);
  endfunction

  always_comb begin
    hdr_cons = (mem_rd_data == TAG_CONS);
    hdr_bad  = (mem_rd_data >= TAG_LIM);
    hdr_last = hdr_cons ? 3'd4 : 3'd1;
    // One extra bit so that an object running past the top of the heap is seen
    // as an overrun instead of wrapping around to address 0.
    end_addr = {1'b0, base} + (ADDR_WIDTH+1)'(hdr_last);
    overrun  = end_addr[ADDR_WIDTH];
    nxt_idx  = idx + 3'd1;
  end

  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      rsp_valid  <= 1'b0;
      rsp_header <= '0;
      rsp_word0  <= '0;
      rsp_word1  <= '0;
      rsp_nil    <= 1'b0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        // IDLE: accept a request and latch the pointer.
        S_IDLE: begin
          if (req_valid) begin
            base <= req_addr;
            idx  <= 3'd0;
            if (req_addr == '0) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_nil    <= 1'b1;
              rsp_error  <= 1'b0;
              rsp_header <= '0;
              rsp_word0  <= '0;
              rsp_word1  <= '0;
            end else begin
              state     <= S_ISSUE;
              mem_rd_en <= 1'b1;
              mem_addr  <= req_addr;
            end
          end
        end
        // ISSUE: the read strobe is high for this cycle only.
        S_ISSUE: begin
          mem_rd_en <= 1'b0;
          state     <= S_CAPTURE;
        end
        // CAPTURE: latch the returned byte, then either read the next byte or respond.
        S_CAPTURE: begin
          if (idx == 3'd0) begin
            tag      <= mem_rd_data;
            is_cons  <= hdr_cons;
            last_idx <= hdr_last;
            if (hdr_bad || overrun) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_error  <= 1'b1;
              rsp_nil    <= 1'b0;
              rsp_header <= mem_rd_data;
              rsp_word0  <= '0;
              rsp_word1  <= '0;
            end else begin
              idx       <= 3'd1;
              state     <= S_ISSUE;
              mem_rd_en <= 1'b1;
              mem_addr  <= base + ADDR_WIDTH'(3'd1);
            end
          end else begin
            byte_buf[idx[1:0]] <= mem_rd_data;
            if (idx == last_idx) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_error  <= 1'b0;
              rsp_nil    <= 1'b0;
              rsp_header <= tag;
              if (is_cons) begin
                rsp_word0 <= ptr12(byte_buf[1], byte_buf[2]);
                rsp_word1 <= ptr12(byte_buf[3], mem_rd_data);
              end else begin
                rsp_word0 <= zext(mem_rd_data);
                rsp_word1 <= '0;
              end
            end else begin
              idx       <= nxt_idx;
              state     <= S_ISSUE;
              mem_rd_en <= 1'b1;
              mem_addr  <= base + ADDR_WIDTH'(nxt_idx);
            end
          end
        end
        // RESP: hold the registered response until the consumer accepts it.
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obj_fetch.sv
module tb_obj_fetch;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_header;
  logic [AW-1:0] rsp_word0;
  logic [AW-1:0] rsp_word1;
  logic          rsp_nil;
  logic          rsp_error;

  obj_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_header(rsp_header),
    .rsp_word0(rsp_word0), .rsp_word1(rsp_word1),
    .rsp_nil(rsp_nil), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  // Heap model: read data comes back the cycle after the strobe.
  logic [7:0] mem [4096];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int rd_count = 0;
  int addr0_count = 0;
  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_count++;
      if (mem_addr == '0) addr0_count++;
    end
  end

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference behaviour, derived from the heap layout and the timing rules:
  // each byte costs two cycles, and the response comes one cycle after the last byte.
  task automatic model(input logic [AW-1:0] a, output int lat, output int nr,
                       output logic [7:0] h, output logic [11:0] w0, output logic [11:0] w1,
                       output logic nil, output logic err);
    int ai, len;
    logic [7:0] t;
    ai = int'(a);
    lat = 0; nr = 0; h = 8'h0; w0 = 12'h0; w1 = 12'h0; nil = 1'b0; err = 1'b0;
    if (ai == 0) begin
      lat = 1; nil = 1'b1;
    end else begin
      t = mem[ai];
      h = t;
      len = (t == 8'd1) ? 5 : 2;
      if (t > 8'd2 || ai + len - 1 > 4095) begin
        err = 1'b1; lat = 3; nr = 1;
      end else begin
        lat = 1 + 2 * len;
        nr = len;
        if (t == 8'd1) begin
          w0 = {mem[ai+1][3:0], mem[ai+2]};
          w1 = {mem[ai+3][3:0], mem[ai+4]};
        end else begin
          w0 = {4'h0, mem[ai+1]};
        end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_header"}, 32'(rsp_header), 32'd0);
    chk({tag, "_rsp_word0"}, 32'(rsp_word0), 32'd0);
    chk({tag, "_rsp_word1"}, 32'(rsp_word1), 32'd0);
    chk({tag, "_rsp_nil"}, 32'(rsp_nil), 32'd0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
  endtask

  // Runs one request from handshake to response acceptance. Every cycle in
  // between is compared against the model. While the request is in flight,
  // req_valid and req_addr carry noise.
  task automatic fetch(input string name, input logic [AW-1:0] a, input int hold,
                       input logic noise);
    int lat, nr, n, r0, z0;
    logic [7:0] h;
    logic [11:0] w0, w1;
    logic nil, err;
    model(a, lat, nr, h, w0, w1, nil, err);
    r0 = rd_count;
    z0 = addr0_count;
    @(negedge clk);
    chk({name, "_idle_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr = a;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = noise;
    req_addr = AW'($urandom);
    n = 1;
    while (!rsp_valid && n < 40) begin
      chk({name, "_busy_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    for (int i = 0; i <= hold; i++) begin
      chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, "_header"}, 32'(rsp_header), 32'(h));
      chk({name, "_word0"}, 32'(rsp_word0), 32'(w0));
      chk({name, "_word1"}, 32'(rsp_word1), 32'(w1));
      chk({name, "_nil"}, 32'(rsp_nil), 32'(nil));
      chk({name, "_error"}, 32'(rsp_error), 32'(err));
      chk({name, "_resp_ready"}, 32'(req_ready), 32'd0);
      chk({name, "_resp_rd_en"}, 32'(mem_rd_en), 32'd0);
      if (i < hold) @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, "_done_ready"}, 32'(req_ready), 32'd1);
    chk({name, "_reads"}, 32'(rd_count - r0), 32'(nr));
    chk({name, "_no_addr0"}, 32'(addr0_count - z0), 32'd0);
  endtask

  initial begin
    int lat, nr, r0;
    logic [7:0] h;
    logic [11:0] w0, w1;
    logic nil, err;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'h00; mem[12'h011] = 8'h2A;
    mem[12'h020] = 8'h01; mem[12'h021] = 8'h03; mem[12'h022] = 8'h40;
    mem[12'h023] = 8'h00; mem[12'h024] = 8'h00;
    mem[12'h030] = 8'h07;
    mem[12'h040] = 8'h02; mem[12'h041] = 8'h99;
    mem[12'h050] = 8'h00; mem[12'h051] = 8'hFF;
    mem[12'h060] = 8'h01; mem[12'h061] = 8'hF5; mem[12'h062] = 8'hAB;
    mem[12'h063] = 8'h3C; mem[12'h064] = 8'hCD;
    mem[12'hFFE] = 8'h01;
    mem[12'hFFF] = 8'h00;

    // Hand-computed anchors for the reference model.
    model(12'h010, lat, nr, h, w0, w1, nil, err);
    chk("pin_num_lat", 32'(lat), 32'd5);
    chk("pin_num_w0", 32'(w0), 32'h02A);
    chk("pin_num_reads", 32'(nr), 32'd2);
    model(12'h020, lat, nr, h, w0, w1, nil, err);
    chk("pin_cons_lat", 32'(lat), 32'd11);
    chk("pin_cons_w0", 32'(w0), 32'h340);
    chk("pin_cons_w1", 32'(w1), 32'h000);
    model(12'h000, lat, nr, h, w0, w1, nil, err);
    chk("pin_nil_lat", 32'(lat), 32'd1);
    model(12'h030, lat, nr, h, w0, w1, nil, err);
    chk("pin_bad_err", 32'(err), 32'd1);
    model(12'hFFF, lat, nr, h, w0, w1, nil, err);
    chk("pin_ovr_lat", 32'(lat), 32'd3);
    model(12'h060, lat, nr, h, w0, w1, nil, err);
    chk("pin_cons2_w0", 32'(w0), 32'h5AB);
    chk("pin_cons2_w1", 32'(w1), 32'hCCD);

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    fetch("number", 12'h010, 0, 1'b0);
    fetch("cons_hold", 12'h020, 4, 1'b1);
    fetch("nil", 12'h000, 1, 1'b0);
    fetch("bad_tag", 12'h030, 0, 1'b1);
    fetch("ovr_num", 12'hFFF, 0, 1'b0);
    fetch("ovr_cons", 12'hFFE, 2, 1'b0);
    fetch("prim", 12'h040, 0, 1'b0);
    fetch("num_ff", 12'h050, 0, 1'b1);
    fetch("cons2", 12'h060, 1, 1'b0);

    // Reset asserted in cycle T+4 of a CONS fetch.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'h020;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midreset");
    r0 = rd_count;
    for (int i = 0; i < 12; i++) begin
      chk("midreset_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("midreset_no_reads", 32'(rd_count - r0), 32'd0);

    // When reset and a request arrive in the same cycle, reset wins.
    rst = 1'b1; req_valid = 1'b1; req_addr = 12'h010;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    chk_reset_vals("rst_prio");
    r0 = rd_count;
    repeat (4) @(negedge clk);
    chk("rst_prio_no_reads", 32'(rd_count - r0), 32'd0);
    chk("rst_prio_no_rsp", 32'(rsp_valid), 32'd0);

    fetch("after_reset", 12'h020, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/obj_fetch.md
OBJ_FETCH -- requirements
Module: obj_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, heap address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, heap word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_addr  input  ADDR_WIDTH  object pointer.
REQ-008 SHALL have port mem_rd_en  output  1  heap read strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  heap read address.
REQ-010 SHALL have port mem_rd_data  input  DATA_WIDTH  heap data, valid the cycle after mem_rd_en.
REQ-011 SHALL have port rsp_valid  output  1  decoded object available.
REQ-012 SHALL have port rsp_ready  input  1  consumer (evaluator) accepts response.
REQ-013 SHALL have port rsp_header  output  DATA_WIDTH  object type tag (NUMBER=0, CONS=1, FUNC_PRIM=2).
REQ-014 SHALL have port rsp_word0  output  ADDR_WIDTH  NUMBER value / FUNC_PRIM id (zero-extended) / CONS car.
REQ-015 SHALL have port rsp_word1  output  ADDR_WIDTH  CONS cdr; zero otherwise.
REQ-016 SHALL have port rsp_nil  output  1  request pointer was NIL.
REQ-017 SHALL have port rsp_error  output  1  bad tag or object overruns the heap.

Function
REQ-018 Heap layout SHALL be: byte A = header; NUMBER: A+1 value; FUNC_PRIM: A+1 primitive id; CONS: car = {mem[A+1][3:0], mem[A+2]}, cdr = {mem[A+3][3:0], mem[A+4]}.
REQ-019 Object lengths SHALL be NUMBER 2, FUNC_PRIM 2, CONS 5 bytes.
REQ-020 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Handshake req_valid&&req_ready in cycle T SHALL latch req_addr; if req_addr==0 (NIL) go to RESP with rsp_nil=1, no memory read, rsp_valid at T+1.
REQ-022 Otherwise ISSUE SHALL drive mem_rd_en=1, mem_addr=A+k for byte k for exactly one cycle; CAPTURE SHALL latch mem_rd_data; each byte costs 2 cycles.
REQ-023 mem_rd_en SHALL be 0 in IDLE, CAPTURE and RESP.
REQ-024 Latency SHALL be: header read at T+1, captured T+2; rsp_valid at T+5 for NUMBER/FUNC_PRIM, T+11 for CONS.
REQ-025 Header not in {0,1,2} SHALL go to RESP with rsp_error=1, rsp_valid at T+3, no further reads.
REQ-026 If A+length-1 > 2^ADDR_WIDTH-1, SHALL not wrap; go to RESP with rsp_error=1, rsp_header=captured tag, rsp_valid at T+3.
REQ-027 In RESP, all rsp_* SHALL be registered and held stable while rsp_valid && !rsp_ready.
REQ-028 rsp_valid&&rsp_ready SHALL return to IDLE next cycle; new request accepted no earlier than that IDLE cycle (no back-to-back overlap).
REQ-029 rsp_nil and rsp_error SHALL be mutually exclusive; unused rsp_word fields SHALL be zero.
REQ-030 req_valid while not in IDLE SHALL be ignored; req_addr changes after acceptance SHALL not affect the fetch.

Reset
REQ-031 rst high at a clock edge SHALL, from the next cycle, put FSM in IDLE, req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_header=0, rsp_word0=0, rsp_word1=0, rsp_nil=0, rsp_error=0.
REQ-032 Reset mid-fetch SHALL abandon the fetch with no response; a read data return after reset SHALL be ignored.
REQ-033 rst SHALL take priority over a simultaneous request handshake.

Verification
REQ-034 mem[0x010]=0x00, mem[0x011]=0x2A, req 0x010 -> rsp_valid at T+5, header 0, word0 0x02A, word1 0, two reads total.
REQ-035 mem[0x020..0x024]=01,03,40,00,00, req 0x020 -> rsp_valid at T+11, header 1, word0 0x340, word1 0x000.
REQ-036 req 0x000 -> rsp_valid at T+1, rsp_nil=1, mem_rd_en never asserted.
REQ-037 mem[0x030]=0x07 -> rsp_error=1 at T+3, one read only; mem[0xFFF]=0x00, req 0xFFF -> rsp_error=1 at T+3, no read at 0x000.
REQ-038 CONS response with rsp_ready held 0 for 4 cycles -> outputs stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-039 rst asserted at T+4 of a CONS fetch -> next cycle all outputs at reset values, no rsp_valid; fresh request then completes normally.
